// File: rtl/core_dma_pkg.sv
// Shared types and constants for the core DMA engine.
package core_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CAPT  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_e;

  localparam logic [2:0] DMA_OP_COPY    = 3'b000;
  localparam logic [2:0] DMA_OP_FILL    = 3'b001;
  localparam int         DMA_WORD_BYTES = 4;

endpackage

// File: rtl/core_dma_engine.sv
// Word-granular memory-to-memory DMA driven by a one-cycle command from EX.
// Optional word-fill operation is compiled in with `define CORE_DMA_FILL_EN.
module core_dma_engine
  import core_dma_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LEN_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dma_en_i,
  input  logic [2:0]       dma_funct3_i,
  input  logic [LEN_W-1:0] dma_imm_i,
  input  logic [XLEN-1:0]  dma_rs1_i,
  input  logic [XLEN-1:0]  dma_rs2_i,
  output logic             dma_busy_o,
  output logic             dma_done_o,
  output logic             dma_err_o,
  output logic             req_o,
  input  logic             gnt_i,
  output logic [XLEN-1:0]  addr_o,
  output logic [XLEN-1:0]  wr_data_o,
  input  logic [XLEN-1:0]  rd_data_i,
  output logic [3:0]       size_o,
  output logic             read_o,
  output logic             write_o
);

  dma_state_e       state_q, state_d;
  logic [XLEN-1:0]  src_q, src_d;
  logic [XLEN-1:0]  dst_q, dst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  buf_q, buf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef CORE_DMA_FILL_EN
  logic             fill_q, fill_d;
`endif

  // Addresses are forced word-aligned, so the low operand bits are dropped.
  logic unused_lsbs;
  assign unused_lsbs = ^{dma_rs1_i[1:0], dma_rs2_i[1:0]};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef CORE_DMA_FILL_EN
    fill_d  = fill_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (dma_en_i) begin
          if (dma_funct3_i == DMA_OP_COPY) begin
            src_d = {dma_rs1_i[XLEN-1:2], 2'b00};
            dst_d = {dma_rs2_i[XLEN-1:2], 2'b00};
            cnt_d = dma_imm_i;
`ifdef CORE_DMA_FILL_EN
            fill_d = 1'b0;
`endif
            if (dma_imm_i == '0) done_d  = 1'b1;
            else                 state_d = ST_READ;
          end
`ifdef CORE_DMA_FILL_EN
          else if (dma_funct3_i == DMA_OP_FILL) begin
            dst_d  = {dma_rs2_i[XLEN-1:2], 2'b00};
            cnt_d  = dma_imm_i;
            buf_d  = dma_rs1_i;
            fill_d = 1'b1;
            if (dma_imm_i == '0) done_d  = 1'b1;
            else                 state_d = ST_WRITE;
          end
`endif
          else begin
            err_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (gnt_i) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        buf_d   = rd_data_i;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (gnt_i) begin
          src_d = src_q + XLEN'(DMA_WORD_BYTES);
          dst_d = dst_q + XLEN'(DMA_WORD_BYTES);
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef CORE_DMA_FILL_EN
            state_d = fill_q ? ST_WRITE : ST_READ;
`else
            state_d = ST_READ;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CORE_DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CORE_DMA_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

  // Bus outputs decode straight from the state register, so they hold while stalled.
  always_comb begin
    read_o    = (state_q == ST_READ);
    write_o   = (state_q == ST_WRITE);
    req_o     = read_o | write_o;
    size_o    = req_o ? 4'b1111 : 4'b0000;
    addr_o    = read_o ? src_q : (write_o ? dst_q : '0);
    wr_data_o = write_o ? buf_q : '0;
  end

  assign dma_busy_o = busy_q;
  assign dma_done_o = done_q;
  assign dma_err_o  = err_q;

endmodule

// File: tb/tb_core_dma_engine.sv
// Self-checking bench for core_dma_engine: command table plus stall and reset sequences.
module tb_core_dma_engine;
  import core_dma_pkg::*;

  localparam int XLEN  = 32;
  localparam int LEN_W = 12;
`ifdef CORE_DMA_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             dma_en_i = 1'b0;
  logic [2:0]       dma_funct3_i = '0;
  logic [LEN_W-1:0] dma_imm_i = '0;
  logic [XLEN-1:0]  dma_rs1_i = '0;
  logic [XLEN-1:0]  dma_rs2_i = '0;
  logic             dma_busy_o, dma_done_o, dma_err_o;
  logic             req_o, gnt_i = 1'b1;
  logic [XLEN-1:0]  addr_o, wr_data_o;
  logic [XLEN-1:0]  rd_data_i = '0;
  logic [3:0]       size_o;
  logic             read_o, write_o;

  always #5 clk = ~clk;

  core_dma_engine #(.XLEN(XLEN), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .dma_en_i(dma_en_i), .dma_funct3_i(dma_funct3_i),
    .dma_imm_i(dma_imm_i), .dma_rs1_i(dma_rs1_i), .dma_rs2_i(dma_rs2_i),
    .dma_busy_o(dma_busy_o), .dma_done_o(dma_done_o), .dma_err_o(dma_err_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .wr_data_o(wr_data_o),
    .rd_data_i(rd_data_i), .size_o(size_o), .read_o(read_o), .write_o(write_o)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hAAAA_0001;
      32'h0000_0104: return 32'hBBBB_0002;
      32'h0000_0108: return 32'hCCCC_0003;
      32'h0000_010C: return 32'hDDDD_0004;
      default:       return {~a[15:0], a[15:0]};
    endcase
  endfunction

  // Memory model: read data appears the cycle after a granted read.
  always @(posedge clk) begin
    if (req_o && read_o && gnt_i) rd_data_i <= memval(addr_o);
  end

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          busy;
    int          done;
    int          err;
    int          req;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input vec_t v);
    logic [31:0] s, d;
    s = {v.rs1[31:2], 2'b00};
    d = {v.rs2[31:2], 2'b00};
    if (v.f3 == DMA_OP_COPY) begin
      for (int i = 0; i < int'(v.imm); i++) exp_q.push_back({d + 32'(4*i), memval(s + 32'(4*i))});
    end else if (FILL_ON && v.f3 == DMA_OP_FILL) begin
      for (int i = 0; i < int'(v.imm); i++) exp_q.push_back({d + 32'(4*i), v.rs1});
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    @(negedge clk);
    dma_en_i     = 1'b1;
    dma_funct3_i = v.f3;
    dma_imm_i    = v.imm;
    dma_rs1_i    = v.rs1;
    dma_rs2_i    = v.rs2;
  endtask

  task automatic run(input vec_t v, input int rd_hold, input int wr_hold);
    int busy_n = 0, done_n = 0, err_n = 0, req_n = 0;
    int done_at = 0, err_at = 0, tail = 0, stall = 0;
    int stab_bad = 0, proto_bad = 0;
    bit finished = 0, prev_stall = 0;
    logic [65:0] prev_sig = '0;
    wr_t e;
    push_expected(v);
    drive_cmd(v);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) dma_en_i = 1'b0;
      if (dma_busy_o) busy_n++;
      if (dma_done_o) begin done_n++; done_at = k; end
      if (dma_err_o)  begin err_n++;  err_at  = k; end
      if (req_o) req_n++;
      if ((req_o && (size_o != 4'hF || read_o == write_o)) || addr_o[1:0] != 2'b00 ||
          (!req_o && (size_o != 4'h0 || addr_o != '0 || read_o || write_o)))
        proto_bad++;
      if (prev_stall && {addr_o, wr_data_o, read_o, write_o} != prev_sig) stab_bad++;
      if (req_o && stall < (read_o ? rd_hold : wr_hold)) begin
        gnt_i = 1'b0; stall++; prev_stall = 1; prev_sig = {addr_o, wr_data_o, read_o, write_o};
      end else begin
        gnt_i = 1'b1; prev_stall = 0;
        if (req_o) stall = 0;
      end
      if (req_o && write_o && gnt_i) begin
        if (exp_q.size() == 0) chk({v.name, " unexpected write"}, {addr_o, wr_data_o}, 64'h0);
        else begin
          e = exp_q.pop_front();
          chk({v.name, " write addr"}, addr_o, e.addr);
          chk({v.name, " write data"}, wr_data_o, e.data);
        end
      end
      if (done_n + err_n > 0) tail++;
      if (tail == 3) begin finished = 1; break; end
    end
    gnt_i = 1'b1;
    chk({v.name, " completes"}, finished, 1);
    chk({v.name, " busy cycles"}, busy_n, v.busy);
    chk({v.name, " done pulses"}, done_n, v.done);
    chk({v.name, " err pulses"}, err_n, v.err);
    chk({v.name, " req cycles"}, req_n, v.req);
    chk({v.name, " done cycle"}, done_at, v.done != 0 ? v.busy + 1 : 0);
    chk({v.name, " err cycle"}, err_at, v.err != 0 ? 1 : 0);
    chk({v.name, " writes left"}, exp_q.size(), 0);
    chk({v.name, " stall stability"}, stab_bad, 0);
    chk({v.name, " bus protocol"}, proto_bad, 0);
    exp_q.delete();
  endtask

  initial begin
    int wr_seen, req_n, done_n;
    vec_t hv;
    vecs[0] = '{"copy4",     3'b000, 12'd4, 32'h0000_0100, 32'h0000_0200, 12, 1, 0, 8};
    vecs[1] = '{"copy0",     3'b000, 12'd0, 32'h0000_0100, 32'h0000_0200, 0,  1, 0, 0};
    vecs[2] = '{"ill101",    3'b101, 12'd4, 32'h0000_0100, 32'h0000_0200, 0,  0, 1, 0};
    if (FILL_ON)
      vecs[3] = '{"fill3",   3'b001, 12'd3, 32'hDEAD_BEEF, 32'hFFFF_FFF8, 3,  1, 0, 3};
    else
      vecs[3] = '{"ill001",  3'b001, 12'd3, 32'hDEAD_BEEF, 32'hFFFF_FFF8, 0,  0, 1, 0};
    vecs[4] = '{"srcwrap",   3'b000, 12'd3, 32'hFFFF_FFF8, 32'h0000_0305, 9,  1, 0, 6};
    vecs[5] = '{"ill111",    3'b111, 12'd0, 32'h0000_0100, 32'h0000_0200, 0,  0, 1, 0};
    vecs[6] = '{"dstwrap",   3'b000, 12'd2, 32'h0000_010A, 32'hFFFF_FFFC, 6,  1, 0, 4};
    vecs[7] = '{"afterrst",  3'b000, 12'd2, 32'h0000_0104, 32'h0000_0700, 6,  1, 0, 4};

    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset outputs", {dma_busy_o, dma_done_o, dma_err_o, req_o, read_o, write_o, size_o},
        '0);
    chk("reset addr/data", {addr_o, wr_data_o}, '0);
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) run(vecs[i], 0, 0);

    hv = '{"stall", 3'b000, 12'd1, 32'h0000_0108, 32'h0000_0500, 8, 1, 0, 7};
    run(hv, 3, 2);

    // Reset during the second write of a four-word copy.
    exp_q.delete();
    gnt_i   = 1'b1;
    wr_seen = 0;
    hv = '{"rst", 3'b000, 12'd4, 32'h0000_0100, 32'h0000_0600, 0, 0, 0, 0};
    drive_cmd(hv);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) dma_en_i = 1'b0;
      if (req_o && write_o) begin
        if (wr_seen == 0) chk("rst first write", {addr_o, wr_data_o}, {32'h0000_0600, 32'hAAAA_0001});
        wr_seen++;
        if (wr_seen == 2) begin rst_i = 1'b1; break; end
      end
    end
    chk("rst reached second write", wr_seen, 2);
    @(negedge clk);
    rst_i = 1'b0;
    chk("rst abort outputs", {dma_busy_o, dma_done_o, dma_err_o, req_o, read_o, write_o, size_o},
        '0);
    chk("rst abort addr/data", {addr_o, wr_data_o}, '0);
    req_n = 0;
    done_n = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_o) req_n++;
      if (dma_done_o) done_n++;
    end
    chk("rst no further req", req_n, 0);
    chk("rst no done", done_n, 0);
    run(vecs[7], 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_dma_engine.md
Name: core_dma_engine

Overview:
Word-granular DMA engine directly downstream of the core's EX stage. Consumes the one-cycle DMA command the core issues from EX (funct3, imm, rs1/rs2 operand values) and performs memory-to-memory copies over a request/grant data-memory port shared with the core. Drives dma_busy_o back to the core, which stalls IF/ID while it is high.

Parameters:
XLEN, 32, address/data width
LEN_W, 12, width of the transfer-length field (taken from dma_imm_i)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
dma_en_i  in  1  command strobe, one cycle, from EX
dma_funct3_i  in  3  operation select
dma_imm_i  in  12  transfer length in words
dma_rs1_i  in  XLEN  source address (copy) or fill value (fill)
dma_rs2_i  in  XLEN  destination address
dma_busy_o  out  1  transfer in progress
dma_done_o  out  1  one-cycle completion pulse
dma_err_o  out  1  one-cycle illegal-command pulse
req_o  out  1  data-memory request
gnt_i  in  1  data-memory grant
addr_o  out  XLEN  word address, bits [1:0] always 0
wr_data_o  out  XLEN  store data
rd_data_i  in  XLEN  load data, valid the cycle after a granted read
size_o  out  4  byte enables, always 4'b1111 when req_o=1, else 0
read_o  out  1  read strobe
write_o  out  1  write strobe

Behaviour:
- Reset (sync, rst_i=1 at posedge): state IDLE; all outputs 0; src/dst/count/buffer registers cleared. Reset mid-transfer aborts immediately: no req_o in the following cycle, no done pulse.
- Commands: funct3 3'b000 = COPY (src=rs1, dst=rs2); 3'b001 = FILL (only with the optional feature); all other values are illegal.
- Accept: dma_en_i=1 in IDLE latches src={rs1[31:2],2'b00}, dst={rs2[31:2],2'b00}, count=imm. dma_en_i outside IDLE is ignored.
- Illegal funct3: no transfer, dma_err_o pulses the next cycle, busy stays 0.
- count==0: no memory access, dma_done_o pulses the next cycle, busy stays 0.
- States: IDLE, READ, CAPT, WRITE.
- READ: req_o=read_o=1, addr_o=src. Hold while gnt_i=0; on gnt_i=1 go to CAPT.
- CAPT: no request; buf<=rd_data_i; go to WRITE.
- WRITE: req_o=write_o=1, addr_o=dst, wr_data_o=buf. Hold while gnt_i=0. On gnt_i=1: src+=4, dst+=4, count-=1. If new count==0, go to IDLE and pulse dma_done_o in that same transition cycle (registered, so visible the cycle after the final grant). Otherwise go to READ.
- While req_o is held without a grant, addr_o, wr_data_o, read_o and write_o stay stable.
- dma_busy_o is registered: 1 from the cycle after accept up to and including the final WRITE grant cycle; 0 in IDLE.
- COPY latency with gnt_i tied high: 3 cycles per word, busy high for 3*N cycles.
- Address arithmetic is modulo 2^XLEN: 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- Source/destination overlap is not detected; copy proceeds in ascending order.

Optional Feature:
Macro CORE_DMA_FILL_EN.
- Defined: funct3 3'b001 = FILL. Accept sets buf=rs1 and enters WRITE directly, skipping READ/CAPT. Cost is 1 cycle per word with gnt high.
- Undefined: 3'b001 is illegal (err pulse, no transfer). FILL logic is absent.

Decomposition:
- Package core_dma_pkg: state enum (IDLE, READ, CAPT, WRITE); funct3 constants DMA_OP_COPY and DMA_OP_FILL; DMA_WORD_BYTES=4.
- Single flat module; no sub-module warranted.

Test Plan:
- COPY, src 0x100, dst 0x200, imm 4, gnt=1, mem[0x100..0x10C]=A,B,C,D: writes A..D to 0x200..0x20C in order; busy high 12 cycles; one done pulse.
- COPY, imm 0: no req_o ever; done pulse the cycle after accept; busy never 1.
- COPY, imm 1, gnt withheld 3 cycles in READ and 2 in WRITE: addr and data stay stable; busy high 3+3+2=8 cycles.
- rst_i asserted in the second WRITE of a 4-word copy: outputs 0 next cycle; remaining words not written; a new command is then accepted normally.
- funct3 3'b101: dma_err_o pulse; no req; busy 0. With CORE_DMA_FILL_EN off, funct3 3'b001 behaves the same.
- CORE_DMA_FILL_EN on, FILL rs1=0xDEADBEEF, rs2=0xFFFF_FFF8, imm 3: writes to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap); busy 3 cycles.
